// File: rtl/jpeg_info_pkg.sv
// Shared definitions for the JPEG encode info record: FSM states, header field
// positions and framing constants, used by both the encoder-side writer and this reader.
package jpeg_info_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAP_HDR  = 3'd1,
    WAIT_LEN = 3'd2,
    CAP_LEN  = 3'd3,
    OUT      = 3'd4
  } info_state_t;

  localparam int SYNC_MSB     = 31;
  localparam int SYNC_LSB     = 24;
  localparam int FRAME_ID_MSB = 23;
  localparam int FRAME_ID_LSB = 16;
  localparam int FLAGS_MSB    = 7;
  localparam int FLAGS_LSB    = 0;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Header word followed by byte-count word.
  localparam int INFO_WORDS = 2;

  function automatic logic [7:0] hdr_sync(input logic [31:0] word);
    return word[SYNC_MSB:SYNC_LSB];
  endfunction

  function automatic logic [7:0] hdr_frame_id(input logic [31:0] word);
    return word[FRAME_ID_MSB:FRAME_ID_LSB];
  endfunction

  function automatic logic [7:0] hdr_flags(input logic [31:0] word);
    return word[FLAGS_MSB:FLAGS_LSB];
  endfunction

  function automatic logic len_bad(input logic [31:0] count, input logic [31:0] max_bytes);
    return (count == 32'd0) || (count > max_bytes);
  endfunction

endpackage

// File: rtl/jpeg_info_sat_cnt.sv
// Saturating up-counter with increment enable; holds at all-ones instead of wrapping.
module jpeg_info_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/jpeg_encode_info_reader.sv
// Pops two-word encode info records from the non-FWFT info FIFO, checks framing
// and hands one frame descriptor per record to the bitstream mover.
//   state    | meaning
//   IDLE     | no read outstanding, waiting for a header word
//   CAP_HDR  | header read returns this cycle; check sync, hunt word-by-word on bad sync
//   WAIT_LEN | header accepted, FIFO empty, waiting for the length word
//   CAP_LEN  | length read returns this cycle
//   OUT      | descriptor presented until info_ready
module jpeg_encode_info_reader
  import jpeg_info_pkg::*;
#(
  parameter int          DATA_WIDTH      = 32,
  parameter logic [7:0]  SYNC_BYTE       = DEFAULT_SYNC_BYTE,
  parameter logic [31:0] MAX_FRAME_BYTES = 32'd4194304,
  parameter int          CNT_WIDTH       = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  info_valid,
  input  logic                  info_ready,
  output logic [7:0]            info_frame_id,
  output logic [7:0]            info_flags,
  output logic [31:0]           info_byte_count,
  output logic                  info_len_err,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  sync_err_cnt,
  output logic                  busy
);

  info_state_t state, state_next;
  logic rd_issue;
  logic load_hdr;
  logic load_len;
  logic sync_inc;
  logic frame_inc;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rd_issue   = 1'b0;
    load_hdr   = 1'b0;
    load_len   = 1'b0;
    sync_inc   = 1'b0;
    frame_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_rd_empty) begin
          rd_issue   = 1'b1;
          state_next = CAP_HDR;
        end
      end
      CAP_HDR: begin
        if (hdr_sync(fifo_rd_data) != SYNC_BYTE) begin
          sync_inc = 1'b1;
          if (!fifo_rd_empty) begin
            rd_issue   = 1'b1;
            state_next = CAP_HDR;
          end else begin
            state_next = IDLE;
          end
        end else begin
          load_hdr = 1'b1;
          if (!fifo_rd_empty) begin
            rd_issue   = 1'b1;
            state_next = CAP_LEN;
          end else begin
            state_next = WAIT_LEN;
          end
        end
      end
      WAIT_LEN: begin
        if (!fifo_rd_empty) begin
          rd_issue   = 1'b1;
          state_next = CAP_LEN;
        end
      end
      CAP_LEN: begin
        load_len   = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        // Nothing is read here, so a stalled consumer backs up into the FIFO.
        if (info_ready) begin
          frame_inc  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Gated with reset so the read strobe is low the instant reset asserts.
  assign fifo_rd_en = rd_issue & ~rd_rst;
  assign info_valid = (state == OUT);
  assign busy       = (state != IDLE);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      info_frame_id   <= '0;
      info_flags      <= '0;
      info_byte_count <= '0;
      info_len_err    <= 1'b0;
    end else begin
      if (load_hdr) begin
        info_frame_id <= hdr_frame_id(fifo_rd_data);
        info_flags    <= hdr_flags(fifo_rd_data);
      end
      if (load_len) begin
        info_byte_count <= fifo_rd_data;
        info_len_err    <= len_bad(fifo_rd_data, MAX_FRAME_BYTES);
      end
    end
  end

  jpeg_info_sat_cnt #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .clk   (rd_clk),
    .rst   (rd_rst),
    .inc   (frame_inc),
    .count (frame_cnt)
  );

  jpeg_info_sat_cnt #(.WIDTH(CNT_WIDTH)) u_sync_err_cnt (
    .clk   (rd_clk),
    .rst   (rd_rst),
    .inc   (sync_inc),
    .count (sync_err_cnt)
  );

endmodule
